vmode_sequencer: RTL and testbench

//  Controls the test-pattern/timing generator. Owns its pal/scandouble mode

---
 rtl/vmode_sequencer.sv | 137 +++++++++++++
 tb/tb_vmode_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmode_sequencer.sv
// rtl/vmode_sequencer.sv - mode/reset sequencer for the test-pattern timing generator
// Applies mode changes at VBlank, holds the generator in reset, waits for frames to lock.
module vmode_sequencer #(
   parameter int RST_CYCLES     = 16,
   parameter int SETTLE_FRAMES  = 2,
   parameter int PATTERN_FRAMES = 60,
   parameter int NUM_PATTERNS   = 4,
   parameter int TIMEOUT        = 2000000,
   parameter bit PAL_DEFAULT    = 1'b0,
   parameter bit SD_DEFAULT     = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic       req_pal,
   input  logic       req_scandouble,
   output logic       req_ready,
   input  logic       auto_cycle,
   input  logic       vsync_in,
   input  logic       vblank_in,
   output logic       gen_reset,
   output logic       pal,
   output logic       scandouble,
   output logic [1:0] pattern_sel,
   output logic       locked,
   output logic       err_timeout
);

   localparam logic [1:0] S_LOCKED = 2'd0;
   localparam logic [1:0] S_PEND   = 2'd1;
   localparam logic [1:0] S_RESET  = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   // One counter serves the PEND timeout, the reset hold and the settle frame count.
   localparam int CMAX_A = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
   localparam int CMAX   = (CMAX_A > SETTLE_FRAMES) ? CMAX_A : SETTLE_FRAMES;
   localparam int CW     = $clog2(CMAX + 1);
   localparam int FW     = $clog2(PATTERN_FRAMES + 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [FW-1:0] frame_cnt;
   logic          vsync_q;
   logic          vblank_q;
   logic          pend_pal;
   logic          pend_sd;
   logic          vs_rise;
   logic          vb_rise;
   logic          mode_differs;

   assign vs_rise      = vsync_in & ~vsync_q;
   assign vb_rise      = vblank_in & ~vblank_q;
   assign req_ready    = (state == S_LOCKED);
   assign locked       = (state == S_LOCKED);
   assign mode_differs = (req_pal != pal) || (req_scandouble != scandouble);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RESET;
         cnt         <= '0;
         frame_cnt   <= '0;
         gen_reset   <= 1'b1;
         pal         <= PAL_DEFAULT;
         scandouble  <= SD_DEFAULT;
         pend_pal    <= PAL_DEFAULT;
         pend_sd     <= SD_DEFAULT;
         pattern_sel <= 2'd0;
         err_timeout <= 1'b0;
         vsync_q     <= 1'b0;
         vblank_q    <= 1'b0;
      end else begin
         vsync_q  <= vsync_in;
         vblank_q <= vblank_in;
         case (state)
            S_LOCKED: begin
               if (req_valid && mode_differs) begin
                  pend_pal <= req_pal;
                  pend_sd  <= req_scandouble;
                  state    <= S_PEND;
                  cnt      <= '0;
               end
               // The pattern step still happens on the cycle a transfer leaves LOCKED.
               if (auto_cycle && vs_rise) begin
                  if (frame_cnt == FW'(PATTERN_FRAMES - 1)) begin
                     frame_cnt   <= '0;
                     pattern_sel <= (pattern_sel == 2'(NUM_PATTERNS - 1)) ? 2'd0
                                                                        : pattern_sel + 2'd1;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            S_PEND: begin
               frame_cnt <= '0;
               if (vb_rise || (cnt == CW'(TIMEOUT - 1))) begin
                  if (!vb_rise) begin
                     err_timeout <= 1'b1;
                  end
                  state      <= S_RESET;
                  cnt        <= '0;
                  gen_reset  <= 1'b1;
                  pal        <= pend_pal;
                  scandouble <= pend_sd;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESET: begin
               frame_cnt <= '0;
               if (cnt == CW'(RST_CYCLES - 1)) begin
                  gen_reset <= 1'b0;
                  state     <= S_SETTLE;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               frame_cnt <= '0;
               if (vs_rise) begin
                  if (cnt == CW'(SETTLE_FRAMES - 1)) begin
                     state <= S_LOCKED;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= S_RESET;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vmode_sequencer.sv
// tb/tb_vmode_sequencer.sv - randomized self-checking bench for vmode_sequencer
module tb_vmode_sequencer;
   localparam int RST_CYCLES     = 16;
   localparam int SETTLE_FRAMES  = 2;
   localparam int PATTERN_FRAMES = 3;
   localparam int NUM_PATTERNS   = 4;
   localparam int TIMEOUT        = 100;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_pal = 1'b0;
   logic       req_scandouble = 1'b0;
   logic       auto_cycle = 1'b0;
   logic       vsync_in = 1'b0;
   logic       vblank_in = 1'b0;
   logic       req_ready;
   logic       gen_reset;
   logic       pal;
   logic       scandouble;
   logic [1:0] pattern_sel;
   logic       locked;
   logic       err_timeout;

   int checks = 0;
   int errors = 0;

   // Reference state: current mode, pattern index, frames toward next step, sticky error.
   bit m_pal, m_sd, m_err;
   int m_pat, m_frames;

   vmode_sequencer #(
      .RST_CYCLES(RST_CYCLES), .SETTLE_FRAMES(SETTLE_FRAMES),
      .PATTERN_FRAMES(PATTERN_FRAMES), .NUM_PATTERNS(NUM_PATTERNS),
      .TIMEOUT(TIMEOUT), .PAL_DEFAULT(1'b0), .SD_DEFAULT(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_pal(req_pal),
      .req_scandouble(req_scandouble), .req_ready(req_ready), .auto_cycle(auto_cycle),
      .vsync_in(vsync_in), .vblank_in(vblank_in), .gen_reset(gen_reset), .pal(pal),
      .scandouble(scandouble), .pattern_sel(pattern_sel), .locked(locked),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_frame();
      if (auto_cycle) begin
         m_frames++;
         if (m_frames == PATTERN_FRAMES) begin
            m_frames = 0;
            m_pat = (m_pat + 1) % NUM_PATTERNS;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      req_valid = 1'b0;
      vsync_in = 1'b0;
      vblank_in = 1'b0;
      repeat (cycles) step();
      reset = 1'b0;
      m_pal = 1'b0; m_sd = 1'b0; m_err = 1'b0; m_pat = 0; m_frames = 0;
   endtask

   task automatic count_gen_reset(output int n);
      n = 0;
      while (gen_reset === 1'b1 && n < 200) begin
         n++;
         step();
      end
   endtask

   task automatic settle(output logic l_mid, output logic l_end);
      vsync_in = 1'b1; step(); vsync_in = 1'b0; step();
      l_mid = locked;
      vsync_in = 1'b1; step();
      l_end = locked;
      vsync_in = 1'b0; step();
   endtask

   task automatic vs_pulse();
      vsync_in = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      vsync_in = 1'b0;
      repeat ($urandom_range(1, 2)) step();
   endtask

   function automatic logic [1:0] other_mode(input logic [1:0] cur);
      return 2'((int'(cur) + int'($urandom_range(1, 3))) % 4);
   endfunction

   task automatic test_reset();
      int n;
      logic l_mid, l_end;
      do_reset(3);
      checks++;
      if ({gen_reset, pal, scandouble, pattern_sel, locked, req_ready, err_timeout} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_values: got %b want 10000000",
                  {gen_reset, pal, scandouble, pattern_sel, locked, req_ready, err_timeout});
      end
      count_gen_reset(n);
      checks++;
      if (n != RST_CYCLES) begin
         errors++;
         $display("FAIL reset_hold: gen_reset high %0d clocks want %0d", n, RST_CYCLES);
      end
      settle(l_mid, l_end);
      checks++;
      if (l_mid !== 1'b0 || l_end !== 1'b1 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_lock: mid=%b end=%b ready=%b want 0 1 1", l_mid, l_end, req_ready);
      end
   endtask

   task automatic test_same_mode();
      bit seen;
      req_valid = 1'b1;
      req_pal = m_pal;
      req_scandouble = m_sd;
      step();
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || locked !== 1'b1) begin
         errors++;
         $display("FAIL same_mode_stay: ready=%b locked=%b want 1 1", req_ready, locked);
      end
      seen = 1'b0;
      repeat (30) begin
         step();
         if (gen_reset === 1'b1 || locked !== 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL same_mode_quiet: gen_reset rose or lock lost, got 1 want 0");
      end
   endtask

   task automatic test_pattern();
      auto_cycle = 1'b1;
      for (int i = 0; i < 14; i++) begin
         model_frame();
         vs_pulse();
         checks++;
         if (pattern_sel !== 2'(m_pat)) begin
            errors++;
            $display("FAIL pattern_step%0d: got %0d want %0d", i, pattern_sel, m_pat);
         end
      end
      auto_cycle = 1'b0;
      repeat ($urandom_range(3, 6)) begin
         model_frame();
         vs_pulse();
      end
      checks++;
      if (pattern_sel !== 2'(m_pat)) begin
         errors++;
         $display("FAIL pattern_hold: got %0d want %0d", pattern_sel, m_pat);
      end
      auto_cycle = 1'b1;
      repeat ($urandom_range(2, 5)) begin
         model_frame();
         vs_pulse();
      end
      checks++;
      if (pattern_sel !== 2'(m_pat)) begin
         errors++;
         $display("FAIL pattern_resume: got %0d want %0d", pattern_sel, m_pat);
      end
   endtask

   task automatic test_mode_change(input int iters);
      logic [1:0] cur, nm;
      int n;
      logic l_mid, l_end;
      for (int it = 0; it < iters; it++) begin
         cur = {m_pal, m_sd};
         nm = other_mode(cur);
         req_valid = 1'b1;
         {req_pal, req_scandouble} = nm;
         step();
         checks++;
         if (req_ready !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL chg_accept: ready=%b locked=%b want 0 0", req_ready, locked);
         end
         // A different request presented while PEND must be ignored.
         {req_pal, req_scandouble} = other_mode(nm);
         repeat ($urandom_range(1, 20)) step();
         req_valid = 1'b0;
         checks++;
         if ({pal, scandouble, gen_reset} !== {cur, 1'b0}) begin
            errors++;
            $display("FAIL chg_pend: got %b want %b", {pal, scandouble, gen_reset}, {cur, 1'b0});
         end
         vblank_in = 1'b1;
         step();
         m_pal = nm[1]; m_sd = nm[0]; m_frames = 0;
         checks++;
         if ({pal, scandouble, gen_reset, err_timeout} !== {nm, 1'b1, m_err}) begin
            errors++;
            $display("FAIL chg_apply: got %b want %b", {pal, scandouble, gen_reset, err_timeout},
                     {nm, 1'b1, m_err});
         end
         vblank_in = 1'b0;
         count_gen_reset(n);
         checks++;
         if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL chg_hold: gen_reset high %0d clocks want %0d", n, RST_CYCLES);
         end
         settle(l_mid, l_end);
         checks++;
         if (l_mid !== 1'b0 || l_end !== 1'b1 || pattern_sel !== 2'(m_pat) || {pal, scandouble} !== nm) begin
            errors++;
            $display("FAIL chg_lock: mid=%b end=%b pat=%0d mode=%b want 0 1 %0d %b",
                     l_mid, l_end, pattern_sel, {pal, scandouble}, m_pat, nm);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] nm;
      int n;
      logic l_mid, l_end;
      auto_cycle = 1'b1;
      nm = other_mode({m_pal, m_sd});
      req_valid = 1'b1;
      {req_pal, req_scandouble} = nm;
      vsync_in = 1'b1;
      model_frame();
      step();
      req_valid = 1'b0;
      vsync_in = 1'b0;
      checks++;
      if (pattern_sel !== 2'(m_pat) || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_step: pat=%0d ready=%b want %0d 0", pattern_sel, req_ready, m_pat);
      end
      m_frames = 0;
      step();
      vblank_in = 1'b1; step(); vblank_in = 1'b0;
      m_pal = nm[1]; m_sd = nm[0];
      count_gen_reset(n);
      settle(l_mid, l_end);
      // Frame counter must restart from zero after the mode change.
      for (int i = 0; i < PATTERN_FRAMES; i++) begin
         model_frame();
         vs_pulse();
         checks++;
         if (pattern_sel !== 2'(m_pat)) begin
            errors++;
            $display("FAIL b2b_restart%0d: got %0d want %0d", i, pattern_sel, m_pat);
         end
      end
   endtask

   task automatic test_timeout();
      logic [1:0] nm;
      int n;
      logic l_mid, l_end;
      nm = other_mode({m_pal, m_sd});
      req_valid = 1'b1;
      {req_pal, req_scandouble} = nm;
      step();
      req_valid = 1'b0;
      n = 0;
      while (gen_reset !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      m_pal = nm[1]; m_sd = nm[0]; m_err = 1'b1; m_frames = 0;
      checks++;
      if (n != TIMEOUT || err_timeout !== 1'b1 || {pal, scandouble} !== nm) begin
         errors++;
         $display("FAIL timeout: clocks=%0d err=%b mode=%b want %0d 1 %b",
                  n, err_timeout, {pal, scandouble}, TIMEOUT, nm);
      end
      count_gen_reset(n);
      settle(l_mid, l_end);
      checks++;
      if (l_end !== 1'b1 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: locked=%b err=%b want 1 1", l_end, err_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic l_mid, l_end;
      req_valid = 1'b1;
      {req_pal, req_scandouble} = other_mode({m_pal, m_sd});
      step();
      req_valid = 1'b0;
      vblank_in = 1'b1; step(); vblank_in = 1'b0;
      count_gen_reset(n);
      vsync_in = 1'b1; step(); vsync_in = 1'b0; step();
      do_reset(2);
      checks++;
      if ({gen_reset, pal, scandouble, pattern_sel, locked, req_ready, err_timeout} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL midreset_values: got %b want 10000000",
                  {gen_reset, pal, scandouble, pattern_sel, locked, req_ready, err_timeout});
      end
      count_gen_reset(n);
      settle(l_mid, l_end);
      checks++;
      if (l_end !== 1'b1 || {pal, scandouble} !== 2'b00 || n != RST_CYCLES) begin
         errors++;
         $display("FAIL midreset_relock: locked=%b mode=%b hold=%0d want 1 00 %0d",
                  l_end, {pal, scandouble}, n, RST_CYCLES);
      end
   endtask

   task automatic test_timeout_tie();
      logic [1:0] nm;
      int n;
      logic l_mid, l_end;
      nm = other_mode({m_pal, m_sd});
      req_valid = 1'b1;
      {req_pal, req_scandouble} = nm;
      step();
      req_valid = 1'b0;
      repeat (TIMEOUT - 1) step();
      checks++;
      if (gen_reset !== 1'b0) begin
         errors++;
         $display("FAIL tie_early: gen_reset=%b want 0", gen_reset);
      end
      vblank_in = 1'b1;
      step();
      vblank_in = 1'b0;
      m_pal = nm[1]; m_sd = nm[0];
      checks++;
      if (gen_reset !== 1'b1 || err_timeout !== 1'b0 || {pal, scandouble} !== nm) begin
         errors++;
         $display("FAIL tie_vblank_wins: gen_reset=%b err=%b mode=%b want 1 0 %b",
                  gen_reset, err_timeout, {pal, scandouble}, nm);
      end
      count_gen_reset(n);
      settle(l_mid, l_end);
   endtask

   initial begin
      test_reset();
      test_same_mode();
      test_pattern();
      test_mode_change(4);
      test_back_to_back();
      test_timeout();
      test_mode_change(1);
      test_reset_mid();
      test_timeout_tie();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
